// File: rtl/uart_tx_frame_mux.sv
// rtl/uart_tx_frame_mux.sv - UART transmit framing stage: start, LSB-first data, optional parity, 1/2 stop bits
// The line bit is selected from the next state and registered, so TX_OUT changes on the state edge.
module uart_tx_frame_mux #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  BIT_TICK,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  accept;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stop_cnt_d = stop_cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    stop2_d    = stop2_q;
    done_d     = 1'b0;
    accept     = 1'b0;
    tx_d       = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (DATA_VALID) begin
          accept  = 1'b1;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (BIT_TICK) state_d = S_START;
      end
      S_START: begin
        if (BIT_TICK) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (BIT_TICK) begin
          if (cnt_q < LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d      = '0;
            stop_cnt_d = 1'b0;
            state_d    = par_en_q ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (BIT_TICK) begin
          state_d    = S_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      S_STOP: begin
        if (BIT_TICK) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            // Final stop tick: a waiting word chains straight into its start bit.
            done_d     = 1'b1;
            stop_cnt_d = 1'b0;
            if (DATA_VALID) begin
              accept  = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      data_d    = P_DATA;
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      stop2_d   = STOP2;
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_q[cnt_d];
      S_PARITY: tx_d = (^data_q) ^ par_typ_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      stop_cnt_q <= 1'b0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stop_cnt_q <= stop_cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = (state_q != S_IDLE);
  assign DONE   = done_q;

endmodule

// File: tb/tb_uart_tx_frame_mux.sv
// tb/tb_uart_tx_frame_mux.sv - scoreboard bench for uart_tx_frame_mux at widths 8 and 5
module tb_uart_tx_frame_mux;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BIT_TICK;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP2;
  logic [7:0] p_data8;
  logic       valid8;
  logic [4:0] p_data5;
  logic       valid5;
  logic       tx8, busy8, done8;
  logic       tx5, busy5, done5;

  int   tests = 0;
  int   fails = 0;
  logic exp_q[$];

  uart_tx_frame_mux #(.DATA_WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .BIT_TICK(BIT_TICK), .P_DATA(p_data8), .DATA_VALID(valid8),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .TX_OUT(tx8), .BUSY(busy8), .DONE(done8)
  );

  uart_tx_frame_mux #(.DATA_WIDTH(5)) dut5 (
    .CLK(CLK), .RST(RST), .BIT_TICK(BIT_TICK), .P_DATA(p_data5), .DATA_VALID(valid5),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .TX_OUT(tx5), .BUSY(busy5), .DONE(done5)
  );

  always #5 CLK = ~CLK;

  function automatic logic obs_tx(int inst);
    return (inst == 5) ? tx5 : tx8;
  endfunction

  function automatic logic obs_busy(int inst);
    return (inst == 5) ? busy5 : busy8;
  endfunction

  function automatic logic obs_done(int inst);
    return (inst == 5) ? done5 : done8;
  endfunction

  function automatic int width_of(int inst);
    return (inst == 5) ? 5 : 8;
  endfunction

  task automatic chk(string tag, logic obs, logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_valid(int inst, logic v, logic [8:0] d);
    if (inst == 5) begin
      valid5  = v;
      p_data5 = d[4:0];
    end else begin
      valid8  = v;
      p_data8 = d[7:0];
    end
  endtask

  // Expected line levels for one frame, one entry per tick interval.
  task automatic push_frame(logic [8:0] d, int w, logic pe, logic pt, logic s2);
    logic par;
    par = pt;
    exp_q.push_back(1'b0);
    for (int i = 0; i < w; i++) begin
      exp_q.push_back(d[i]);
      par = par ^ d[i];
    end
    if (pe) exp_q.push_back(par);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endtask

  // A tick in the acceptance cycle must be ignored.
  task automatic accept(int inst, logic [8:0] d, logic pe, logic pt, logic s2);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    STOP2    = s2;
    BIT_TICK = 1'b1;
    drive_valid(inst, 1'b1, d);
    push_frame(d, width_of(inst), pe, pt, s2);
    step();
    valid8   = 1'b0;
    valid5   = 1'b0;
    BIT_TICK = 1'b0;
    chk("acc_busy", obs_busy(inst), 1'b1);
    chk("acc_tx", obs_tx(inst), 1'b1);
    chk("acc_done", obs_done(inst), 1'b0);
  endtask

  task automatic play(int inst, int nbits, int per, bit first_shown, bit end_valid,
                      logic [8:0] end_data, bit disturb);
    logic e;
    for (int b = 0; b < nbits; b++) begin
      if (!(b == 0 && first_shown)) begin
        BIT_TICK = 1'b1;
        step();
        BIT_TICK = 1'b0;
      end
      e = exp_q.pop_front();
      chk("tx_bit", obs_tx(inst), e);
      chk("busy_frame", obs_busy(inst), 1'b1);
      chk("done_frame", obs_done(inst), logic'(b == 0 && first_shown));
      for (int k = 1; k < per; k++) begin
        if (disturb) begin
          valid8  = 1'b1;
          p_data8 = 8'hFF;
          PAR_EN  = ~PAR_EN;
          STOP2   = ~STOP2;
        end
        step();
        chk("tx_hold", obs_tx(inst), e);
        chk("done_hold", obs_done(inst), 1'b0);
      end
    end
    valid8 = 1'b0;
    valid5 = 1'b0;
    if (disturb) begin
      PAR_EN = 1'b0;
      STOP2  = 1'b0;
    end
    BIT_TICK = 1'b1;
    if (end_valid) begin
      drive_valid(inst, 1'b1, end_data);
      push_frame(end_data, width_of(inst), PAR_EN, PAR_TYP, STOP2);
    end
    step();
    BIT_TICK = 1'b0;
    valid8   = 1'b0;
    valid5   = 1'b0;
    chk("done_end", obs_done(inst), 1'b1);
    chk("busy_end", obs_busy(inst), logic'(end_valid));
    if (!end_valid) begin
      chk("tx_end", obs_tx(inst), 1'b1);
      step();
      chk("done_once", obs_done(inst), 1'b0);
      chk("busy_idle", obs_busy(inst), 1'b0);
    end
  endtask

  initial begin
    RST      = 1'b1;
    BIT_TICK = 1'b0;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    STOP2    = 1'b0;
    p_data8  = '0;
    valid8   = 1'b0;
    p_data5  = '0;
    valid5   = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      BIT_TICK = 1'($urandom);
      PAR_EN   = 1'($urandom);
      PAR_TYP  = 1'($urandom);
      STOP2    = 1'($urandom);
      valid8   = 1'($urandom);
      valid5   = 1'($urandom);
      p_data8  = 8'($urandom);
      p_data5  = 5'($urandom);
      step();
      chk("rst_tx8", tx8, 1'b1);
      chk("rst_busy8", busy8, 1'b0);
      chk("rst_done8", done8, 1'b0);
      chk("rst_tx5", tx5, 1'b1);
      chk("rst_busy5", busy5, 1'b0);
      chk("rst_done5", done5, 1'b0);
    end
    RST    = 1'b0;
    valid8 = 1'b0;
    valid5 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      BIT_TICK = 1'(i);
      step();
      chk("idle_tick_tx", tx8, 1'b1);
      chk("idle_tick_busy", busy8, 1'b0);
    end
    BIT_TICK = 1'b0;

    // 8'hA5, no parity, one stop, tick every 4 cycles
    accept(8, 9'h0A5, 1'b0, 1'b0, 1'b0);
    play(8, 10, 4, 1'b0, 1'b0, 9'h0, 1'b0);

    // 8'h07 with parity and two stops, even then odd
    accept(8, 9'h007, 1'b1, 1'b0, 1'b1);
    play(8, 12, 2, 1'b0, 1'b0, 9'h0, 1'b0);
    accept(8, 9'h007, 1'b1, 1'b1, 1'b1);
    play(8, 12, 2, 1'b0, 1'b0, 9'h0, 1'b0);

    // Width 5, tick held high every cycle
    accept(5, 9'h015, 1'b1, 1'b0, 1'b1);
    play(5, 9, 1, 1'b0, 1'b0, 9'h0, 1'b0);
    accept(5, 9'h015, 1'b1, 1'b1, 1'b1);
    play(5, 9, 1, 1'b0, 1'b0, 9'h0, 1'b0);

    // Back-to-back frames
    accept(8, 9'h055, 1'b0, 1'b0, 1'b0);
    play(8, 10, 3, 1'b0, 1'b1, 9'h00F, 1'b0);
    play(8, 10, 3, 1'b1, 1'b0, 9'h0, 1'b0);

    // Mid-frame interference
    accept(8, 9'h03C, 1'b0, 1'b0, 1'b0);
    play(8, 10, 3, 1'b0, 1'b0, 9'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_ff_busy", busy8, 1'b0);
      chk("no_ff_tx", tx8, 1'b1);
    end

    // Reset during data bit 3
    accept(8, 9'h03C, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      BIT_TICK = 1'b1;
      step();
      BIT_TICK = 1'b0;
      step();
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("abort_tx", tx8, 1'b1);
    chk("abort_busy", busy8, 1'b0);
    chk("abort_done", done8, 1'b0);
    step();
    chk("abort_done2", done8, 1'b0);
    accept(8, 9'h081, 1'b0, 1'b0, 1'b0);
    play(8, 10, 2, 1'b0, 1'b0, 9'h0, 1'b0);

    chk("queue_empty", logic'(exp_q.size() == 0), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
